// File: rtl/bitwise_unit_pipe.sv
// bitwise_unit_pipe: registered 8-op bitwise unit with a 2-entry valid/ready output buffer
// Ports:
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   in_valid, in_ready    upstream handshake; operands and op sampled on accept
//   in_a, in_b, op        operands and operation select (0 NOT a .. 7 pass a)
//   out_valid, out_ready  downstream handshake
//   out_data              head result of the buffer
//   out_zero, out_neg     flags stored alongside each buffered result
module bitwise_unit_pipe #(
    parameter int WIDTH = 16,
    parameter int OPW = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [OPW-1:0]   op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero,
    output logic             out_neg
);
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] data_q [2];
    logic [1:0]       zero_q;
    logic [1:0]       neg_q;
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic             accept;
    logic             pop;

    always_comb begin
        case (op)
            3'd0:    res = ~in_a;
            3'd1:    res = in_a & in_b;
            3'd2:    res = in_a | in_b;
            3'd3:    res = in_a ^ in_b;
            3'd4:    res = ~(in_a & in_b);
            3'd5:    res = ~(in_a | in_b);
            3'd6:    res = ~(in_a ^ in_b);
            default: res = in_a;
        endcase
    end

    // in_ready depends only on the registered count, so out_ready never reaches it combinationally
    assign in_ready  = count != 2'd2;
    assign out_valid = count != 2'd0;
    assign accept    = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_data  = data_q[rd_ptr];
    assign out_zero  = zero_q[rd_ptr];
    assign out_neg   = neg_q[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '{default: '0};
            zero_q <= '0;
            neg_q  <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= '0;
        end else begin
            if (accept) begin
                data_q[wr_ptr] <= res;
                zero_q[wr_ptr] <= res == '0;
                neg_q[wr_ptr]  <= res[WIDTH-1];
                wr_ptr         <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, accept} - {1'b0, pop};
        end
    end
endmodule

// File: tb/tb_bitwise_unit_pipe.sv
// tb_bitwise_unit_pipe: scoreboard bench for bitwise_unit_pipe (WIDTH=16 and WIDTH=6 instances)
module tb_bitwise_unit_pipe;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready, out_zero, out_neg;
    logic [15:0] in_a, in_b, out_data;
    logic [2:0]  op;
    logic        in_valid6, in_ready6, out_valid6, out_ready6, out_zero6, out_neg6;
    logic [5:0]  in_a6, in_b6, out_data6;
    logic [2:0]  op6;
    int          total = 0;
    int          bad = 0;
    logic [17:0] sb[$];
    logic [5:0]  sb6[$];

    always #5 clk = ~clk;

    bitwise_unit_pipe #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_zero(out_zero), .out_neg(out_neg)
    );

    bitwise_unit_pipe #(.WIDTH(6)) dut6 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid6), .in_ready(in_ready6),
        .in_a(in_a6), .in_b(in_b6), .op(op6), .out_valid(out_valid6), .out_ready(out_ready6),
        .out_data(out_data6), .out_zero(out_zero6), .out_neg(out_neg6)
    );

    // reference result packed as {zero, neg, data}
    function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b, input logic [2:0] o);
        logic [15:0] r;
        case (o)
            3'd0:    r = ~a;
            3'd1:    r = a & b;
            3'd2:    r = a | b;
            3'd3:    r = a ^ b;
            3'd4:    r = ~(a & b);
            3'd5:    r = ~(a | b);
            3'd6:    r = ~(a ^ b);
            default: r = a;
        endcase
        return {r == 16'h0, r[15], r};
    endfunction

    task automatic test_reset();
        total++;
        if (out_valid !== 1'b0 || out_data !== 16'h0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_initial: valid=%b data=%h ready=%b required 0 0000 1", out_valid, out_data, in_ready);
        end
        rst_n = 1'b1;
        out_ready = 1'b0;
        in_valid = 1'b1; in_a = 16'hFFFF; in_b = 16'hFFFF; op = 3'd1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_neg !== 1'b1) begin
            bad++;
            $display("FAIL reset_fill: ready=%b valid=%b neg=%b required 0 1 1", in_ready, out_valid, out_neg);
        end
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || out_data !== 16'h0 || out_neg !== 1'b0 || out_zero !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_async: valid=%b data=%h neg=%b zero=%b ready=%b required 0 0000 0 0 1",
                     out_valid, out_data, out_neg, out_zero, in_ready);
        end
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                bad++;
                $display("FAIL reset_stale: cycle %0d valid=%b ready=%b required 0 1", c, out_valid, in_ready);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_op_sweep();
        logic [15:0] tbl [8];
        logic [17:0] e;
        tbl = '{16'h0F0F, 16'hF000, 16'hFFF0, 16'h0FF0, 16'h0FFF, 16'h000F, 16'hF00F, 16'hF0F0};
        out_ready = 1'b1;
        for (int i = 0; i <= 8; i++) begin
            if (i < 8) begin
                in_valid = 1'b1; in_a = 16'hF0F0; in_b = 16'hFF00; op = 3'(i);
                sb.push_back(model(in_a, in_b, op));
            end else
                in_valid = 1'b0;
            @(negedge clk);
            if (i > 0) begin
                total++;
                if (out_valid !== 1'b1 || out_data !== tbl[i-1] || out_neg !== tbl[i-1][15] || out_zero !== 1'b0) begin
                    bad++;
                    $display("FAIL sweep_op%0d: valid=%b data=%h neg=%b zero=%b required 1 %h %b 0",
                             i - 1, out_valid, out_data, out_neg, out_zero, tbl[i-1], tbl[i-1][15]);
                end
            end
            if (out_valid && out_ready) begin
                e = sb.size() > 0 ? sb.pop_front() : 18'h3FFFF;
                total++;
                if ({out_zero, out_neg, out_data} !== e) begin
                    bad++;
                    $display("FAIL sb_sweep: got %h required %h", {out_zero, out_neg, out_data}, e);
                end
            end
            @(posedge clk); #1;
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL sweep_drain: %0d results outstanding, required 0", sb.size());
        end
    endtask

    task automatic test_flags();
        logic [17:0] e;
        out_ready = 1'b1;
        for (int i = 0; i <= 2; i++) begin
            in_valid = i < 2;
            in_a = i == 0 ? 16'h00FF : 16'h0000;
            in_b = 16'hFF00;
            op = i == 0 ? 3'd1 : 3'd0;
            if (i < 2) sb.push_back(model(in_a, in_b, op));
            @(negedge clk);
            if (i == 1) begin
                total++;
                if (out_valid !== 1'b1 || out_data !== 16'h0000 || out_zero !== 1'b1 || out_neg !== 1'b0) begin
                    bad++;
                    $display("FAIL flags_zero: data=%h zero=%b neg=%b required 0000 1 0", out_data, out_zero, out_neg);
                end
            end
            if (i == 2) begin
                total++;
                if (out_valid !== 1'b1 || out_data !== 16'hFFFF || out_zero !== 1'b0 || out_neg !== 1'b1) begin
                    bad++;
                    $display("FAIL flags_neg: data=%h zero=%b neg=%b required FFFF 0 1", out_data, out_zero, out_neg);
                end
            end
            if (out_valid && out_ready) begin
                e = sb.size() > 0 ? sb.pop_front() : 18'h3FFFF;
                total++;
                if ({out_zero, out_neg, out_data} !== e) begin
                    bad++;
                    $display("FAIL sb_flags: got %h required %h", {out_zero, out_neg, out_data}, e);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_pressure();
        logic [15:0] exp_bp [3];
        logic [17:0] e;
        logic        acc;
        int          j = 0;
        exp_bp = '{16'h0003, 16'h0002, 16'hFFFF};
        out_ready = 1'b0;
        in_valid = 1'b1; in_a = 16'd1; in_b = 16'd2; op = 3'd3;
        sb.push_back(model(in_a, in_b, op));
        @(posedge clk); #1;
        in_a = 16'd3; in_b = 16'd1; op = 3'd3;
        sb.push_back(model(in_a, in_b, op));
        @(posedge clk); #1;
        in_a = 16'd0; in_b = 16'h1234; op = 3'd0;
        sb.push_back(model(in_a, in_b, op));
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 16'h0003) begin
                bad++;
                $display("FAIL bp_hold: cycle %0d ready=%b valid=%b data=%h required 0 1 0003", c, in_ready, out_valid, out_data);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                e = sb.size() > 0 ? sb.pop_front() : 18'h3FFFF;
                total++;
                if ({out_zero, out_neg, out_data} !== e || j > 2 || out_data !== exp_bp[j > 2 ? 2 : j]) begin
                    bad++;
                    $display("FAIL bp_order: pop %0d got %h required %h", j, out_data, e[15:0]);
                end
                j++;
            end
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) in_valid = 1'b0;
        end
        total++;
        if (j != 3 || sb.size() != 0 || in_valid !== 1'b0) begin
            bad++;
            $display("FAIL bp_drain: pops=%0d left=%0d in_valid=%b required 3 0 0", j, sb.size(), in_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [17:0] e;
        out_ready = 1'b0;
        in_valid = 1'b1; in_a = 16'h8001; in_b = 16'h7FFE; op = 3'd2;
        sb.push_back(model(in_a, in_b, op));
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            in_valid = k <= 10;
            in_a = 16'(k * 16'h1357);
            in_b = 16'(k * 16'h0F0F) ^ 16'hA5A5;
            op = 3'(k);
            if (k <= 10) sb.push_back(model(in_a, in_b, op));
            @(negedge clk);
            if (k <= 10) begin
                total++;
                if (out_valid !== 1'b1 || in_ready !== 1'b1) begin
                    bad++;
                    $display("FAIL b2b_count: cycle %0d valid=%b ready=%b required 1 1", k, out_valid, in_ready);
                end
            end
            if (out_valid && out_ready) begin
                e = sb.size() > 0 ? sb.pop_front() : 18'h3FFFF;
                total++;
                if ({out_zero, out_neg, out_data} !== e) begin
                    bad++;
                    $display("FAIL sb_b2b: cycle %0d got %h required %h", k, {out_zero, out_neg, out_data}, e);
                end
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0 || sb.size() != 0) begin
            bad++;
            $display("FAIL b2b_drain: valid=%b left=%0d required 0 0", out_valid, sb.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic test_width6();
        logic [5:0] e;
        logic       stop = 1'b0;
        out_ready6 = 1'b1;
        for (int i = 0; i <= 64 && !stop; i++) begin
            in_valid6 = i < 64;
            in_a6 = 6'(i);
            if (i < 64) sb6.push_back(6'(63 - i));
            @(negedge clk);
            if (i > 0) begin
                e = sb6.size() > 0 ? sb6.pop_front() : 6'h0;
                total++;
                if (out_valid6 !== 1'b1 || out_data6 !== e) begin
                    bad++;
                    stop = 1'b1;
                    $display("FAIL w6_not: pattern %0d got %0d valid=%b required %0d -- Failed", i - 1, out_data6, out_valid6, e);
                end else
                    $display("w6 pattern %0d Pass", i - 1);
            end
            @(posedge clk); #1;
        end
        in_valid6 = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; in_a = '0; in_b = '0; op = '0; out_ready = 1'b0;
        in_valid6 = 1'b0; in_a6 = '0; in_b6 = 6'h2A; op6 = 3'd0; out_ready6 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_op_sweep();
        test_flags();
        test_back_pressure();
        test_back_to_back();
        test_width6();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bitwise_unit_pipe.md
Name: bitwise_unit_pipe

Overview:
- Parametrised, registered bitwise logic unit for the Computer16 datapath. It generalises the fixed-width combinational inverter to any WIDTH.
- Supports eight selectable bitwise operations on two operands.
- Results pass through a 2-entry output buffer with valid/ready handshakes on both sides, so the ALU/register stages can apply back-pressure without dropping operands.

Parameters:
- WIDTH, 16, operand and result width in bits (legal range 1..64).
- OPW, 3, width of the op select field (fixed at 3; eight operations).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  upstream presents an operand set
- in_ready  output  1  block can accept an operand set this cycle
- in_a  input  WIDTH  operand A
- in_b  input  WIDTH  operand B (ignored for ops 0 and 7)
- op  input  OPW  operation select, sampled with the operands
- out_valid  output  1  out_data/flags hold a valid result
- out_ready  input  1  downstream accepts the result this cycle
- out_data  output  WIDTH  result
- out_zero  output  1  result == 0
- out_neg  output  1  result MSB (bit WIDTH-1)

Behaviour:
- Interface decision: one clock, clk; asynchronous active-low reset, rst_n.
- Op encoding:
  - 0 NOT a
  - 1 a AND b
  - 2 a OR b
  - 3 a XOR b
  - 4 NOT(a AND b)
  - 5 NOT(a OR b)
  - 6 NOT(a XOR b)
  - 7 pass a
- Result is computed combinationally from in_a/in_b/op and written into the buffer on accept. out_zero and out_neg are stored with each entry, not recomputed at the output.
- Accept = in_valid && in_ready. Pop = out_valid && out_ready.
- Buffer is a 2-entry FIFO:
  - write pointer, read pointer (1 bit each, wrap 1->0), count 0..2.
  - in_ready = (count != 2), derived from registered state only; no combinational path from out_ready to in_ready.
  - out_valid = (count != 0). out_data/out_zero/out_neg = head entry.
- Count update per edge:
  - accept only: +1
  - pop only: -1
  - both: unchanged, with the head advanced and the new entry written at the tail.
  - count==2: accept impossible; pop only.
  - count==0: pop impossible. An accept makes out_valid high on the next cycle.
- Latency: an operand accepted at edge N is visible on out_data after edge N (1 cycle) when the buffer was empty.
- Throughput: 1 result/cycle sustained while out_ready is held high.
- Ordering: strict FIFO; results are never reordered, dropped or duplicated.
- While out_valid is high and out_ready is low, out_data/out_zero/out_neg hold stable.
- in_a/in_b/op are don't-care when in_valid is low, and must not affect state.
- Reset (asynchronous, any time, including mid-transfer):
  - count=0, pointers=0, out_valid=0, out_data=0, out_zero=0, out_neg=0.
  - in_ready=1 once rst_n is released.
  - Buffered results are discarded.
- No X propagation to outputs after reset, for any op value 0..7.

Test Plan:
- Reset: assert rst_n=0 mid-run with count=2 -> out_valid=0, out_data=0, in_ready=1 immediately after deassertion; no stale result emerges.
- Op sweep (WIDTH=16, out_ready=1): a=16'hF0F0, b=16'hFF00, ops 0..7 -> 0F0F, F000, FFF0, 0FF0, 0FFF, 000F, F00F, F0F0, each one cycle after accept. out_neg per bit15 (0,1,1,0,0,0,1,1); out_zero=0.
- Zero/neg flags: op1 with a=16'h00FF, b=16'hFF00 -> out_data=0000, out_zero=1, out_neg=0. op0 with a=16'h0000 -> FFFF, out_neg=1.
- Back-pressure: out_ready=0, push three ops (XOR 1/2, XOR 3/1, NOT 0) -> in_ready drops after two accepts, third held. Raise out_ready -> outputs 0003, 0002, FFFF in order, none lost.
- Simultaneous push/pop at count=1 for 10 cycles -> count stays 1, outputs match the input sequence with 1-cycle latency.
- WIDTH=6 instance, op 0, all 64 inputs 0..63 streamed with out_ready=1 -> out_data = 63 - input for every pattern. Bench prints per-pattern Pass/Failed and stops on the first failure.
